// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR generator: default tap mask and the
// active-low hexadecimal seven-segment code table (bit7..bit1 = a..g, bit0 = dp).
package lfsr_pkg;

  localparam logic [7:0] LFSR_TAPS8 = 8'h1D;

  // Active-low codes, dp held off (1).
  localparam logic [7:0] SegTable [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    return SegTable[nib];
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Board-side bundle of the LFSR generator: control inputs from switches/buttons
// and the state, counter, flags and segment outputs toward LEDs and digits.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned DIGITS = WIDTH / 4;

  logic                  load;
  logic [WIDTH-1:0]      seed;
  logic                  step;
  logic                  run;
  logic [WIDTH-1:0]      value;
  logic [WIDTH-1:0]      count;
  logic                  wrap;
  logic                  seed_fix;
  logic [DIGITS*8-1:0]   seg;

  modport master (
    output load, seed, step, run,
    input  value, count, wrap, seed_fix, seg
  );

  modport slave (
    input  load, seed, step, run,
    output value, count, wrap, seed_fix, seg
  );

endinterface

// File: rtl/hex_seg_dec.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_seg_dec
  import lfsr_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  // Table lookup; dp is always off.
  always_comb begin
    seg = hex2seg(nib);
  end

endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR generator with seed load, synchronised single-step button,
// prescaled free-run mode, advance counter, period-wrap pulse and a registered
// hex seven-segment readout. Define LFSR_SEG_EN to build the segment decoders;
// without it the seg port is tied blank (all ones).
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_TAPS8),
  parameter int unsigned      PRESCALE = 50_000_000
) (
  input logic       clk,
  input logic       rst,
  lfsr_gen_if.slave bus
);

  localparam int unsigned      PsWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsWidth-1:0] PsMax = PsWidth'(PRESCALE - 1);

  logic               s1_q, s2_q, s3_q;
  logic [PsWidth-1:0] ps_q, ps_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               wrap_q, wrap_d;
  logic               fix_q, fix_d;

  logic               step_edge;
  logic               tick;
  logic               advance;
  logic [WIDTH-1:0]   lfsr_next;
  logic [WIDTH-1:0]   seed_applied;

  assign step_edge    = s2_q & ~s3_q;
  assign tick         = bus.run && (ps_q == PsMax);
  assign advance      = step_edge | tick;
  assign lfsr_next    = {^(value_q & TAPS), value_q[WIDTH-1:1]};
  // Zero seed would lock the register up, so it is replaced by 1.
  assign seed_applied = (bus.seed == '0) ? WIDTH'(1) : bus.seed;

  // Step button synchroniser and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.step;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Run-mode prescaler: counts while run is high, cleared by load or run low.
  always_comb begin
    ps_d = ps_q + PsWidth'(1);
    if (!bus.run || bus.load || (ps_q == PsMax)) begin
      ps_d = '0;
    end
  end

  // Next-state: load has priority over any advance in the same cycle.
  always_comb begin
    value_d = value_q;
    ref_d   = ref_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    fix_d   = fix_q;
    if (bus.load) begin
      value_d = seed_applied;
      ref_d   = seed_applied;
      count_d = '0;
      fix_d   = (bus.seed == '0);
    end else if (advance) begin
      value_d = lfsr_next;
      count_d = count_q + WIDTH'(1);
      wrap_d  = (lfsr_next == ref_q);
    end
  end

  // Generator state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q    <= '0;
      value_q <= WIDTH'(1);
      ref_q   <= WIDTH'(1);
      count_q <= '0;
      wrap_q  <= 1'b0;
      fix_q   <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      value_q <= value_d;
      ref_q   <= ref_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      fix_q   <= fix_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.seed_fix = fix_q;

`ifdef LFSR_SEG_EN
  localparam int unsigned DIGITS = WIDTH / 4;
  // Reset shows value 1: digit 0 reads "1", higher digits read "0".
  localparam logic [DIGITS*8-1:0] SegZero  = {DIGITS{hex2seg(4'h0)}};
  localparam logic [DIGITS*8-1:0] SegReset = (SegZero & ~((DIGITS*8)'(8'hFF))) |
                                             (DIGITS*8)'(hex2seg(4'h1));

  logic [DIGITS*8-1:0] seg_d, seg_q;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    hex_seg_dec u_dec (
      .nib (value_q[4*k +: 4]),
      .seg (seg_d[8*k +: 8])
    );
  end

  // Segment register, one cycle behind value.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SegReset;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign bus.seg = seg_q;
`else
  assign bus.seg = '1;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: an 8-bit instance (PRESCALE=1) and a
// 16-bit instance (TAPS=16'h002D, PRESCALE=4) run side by side against a
// behavioural model of the generator rules.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(8))  bus8 ();
  lfsr_gen_if #(.WIDTH(16)) bus16 ();

  lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .PRESCALE(1)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  lfsr_gen #(.WIDTH(16), .TAPS(16'h002D), .PRESCALE(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  typedef struct packed {
    logic [31:0] value;
    logic [31:0] refv;
    logic [31:0] count;
    logic        wrap;
    logic        fix;
    logic [63:0] seg;
    logic [2:0]  hist;   // step samples, [0] newest
    logic [31:0] runc;   // consecutive run cycles without load
  } model_t;

  model_t m8, m16;
  int n_checks = 0;
  int n_fail   = 0;

  // Segments lit (a..g) for each hex digit.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [63:0] model_seg(input logic [31:0] v, input int digits);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < digits; k++) begin
`ifdef LFSR_SEG_EN
      r[8*k +: 8] = ~{seg_pattern(4'((v >> (4 * k)) & 32'hF)), 1'b0};
`else
      r[8*k +: 8] = 8'hFF;
`endif
    end
    return r;
  endfunction

  // One rising edge of the generator as described by its rules.
  function automatic model_t model_edge(input model_t s, input int w, input logic [31:0] taps,
                                        input int p, input logic r, input logic ld,
                                        input logic [31:0] seed, input logic stp,
                                        input logic rn);
    model_t      n;
    logic [31:0] mask;
    logic [31:0] sd;
    logic [31:0] nv;
    logic        req;
    logic        tick;
    n    = s;
    mask = (32'd1 << w) - 32'd1;
    sd   = seed & mask;
    if (r) begin
      n       = '0;
      n.value = 32'd1;
      n.refv  = 32'd1;
      n.seg   = model_seg(32'd1, w / 4);
      return n;
    end
    n.seg  = model_seg(s.value, w / 4);
    n.hist = {s.hist[1:0], stp};
    req    = s.hist[1] & ~s.hist[2];
    tick   = rn && !ld && (((s.runc + 32'd1) % 32'(p)) == 32'd0);
    n.runc = (rn && !ld) ? s.runc + 32'd1 : 32'd0;
    n.wrap = 1'b0;
    if (ld) begin
      n.value = (sd == 32'd0) ? 32'd1 : sd;
      n.refv  = n.value;
      n.count = 32'd0;
      n.fix   = (sd == 32'd0);
    end else if (req || tick) begin
      nv      = ((s.value >> 1) | (32'($countones(s.value & taps) % 2) << (w - 1))) & mask;
      n.value = nv;
      n.count = (s.count + 32'd1) & mask;
      n.wrap  = (nv == s.refv);
    end
    return n;
  endfunction

  function automatic logic [33:0] obs8();
    return {bus8.value, bus8.count, bus8.wrap, bus8.seed_fix, bus8.seg};
  endfunction

  function automatic logic [33:0] exp8();
    return {m8.value[7:0], m8.count[7:0], m8.wrap, m8.fix, m8.seg[15:0]};
  endfunction

  function automatic logic [65:0] obs16();
    return {bus16.value, bus16.count, bus16.wrap, bus16.seed_fix, bus16.seg};
  endfunction

  function automatic logic [65:0] exp16();
    return {m16.value[15:0], m16.count[15:0], m16.wrap, m16.fix, m16.seg[31:0]};
  endfunction

  // Advance one clock and both models; outputs are then sampled 1 unit later.
  task automatic cycle();
    @(posedge clk);
    m8  = model_edge(m8, 8, 32'h1D, 1, rst, bus8.load, 32'(bus8.seed), bus8.step, bus8.run);
    m16 = model_edge(m16, 16, 32'h2D, 4, rst, bus16.load, 32'(bus16.seed), bus16.step,
                     bus16.run);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_seg;
`ifdef LFSR_SEG_EN
    exp_seg = 16'h039F;
`else
    exp_seg = 16'hFFFF;
`endif
    rst = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (obs8() !== exp8()) begin
      n_fail++;
      $display("FAIL reset8: got %h expected %h", obs8(), exp8());
    end
    n_checks++;
    if (obs16() !== exp16()) begin
      n_fail++;
      $display("FAIL reset16: got %h expected %h", obs16(), exp16());
    end
    n_checks++;
    if ({bus8.value, bus8.count, bus8.wrap, bus8.seg} !== {8'h01, 8'h00, 1'b0, exp_seg}) begin
      n_fail++;
      $display("FAIL reset_literal: got %h %h %b %h expected 01 00 0 %h",
               bus8.value, bus8.count, bus8.wrap, bus8.seg, exp_seg);
    end
    rst = 1'b0;
  endtask

  task automatic test_run_sequence();
    logic [7:0]  exp_seq [6];
    logic [15:0] seg88;
    exp_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4};
`ifdef LFSR_SEG_EN
    seg88 = 16'h0101;
`else
    seg88 = 16'hFFFF;
`endif
    bus8.seed = 8'h01;
    bus8.load = 1'b1;
    bus8.run  = 1'b1;
    cycle();
    bus8.load = 1'b0;
    n_checks++;
    if (bus8.value !== 8'h01) begin
      n_fail++;
      $display("FAIL seq_load: got %h expected 01", bus8.value);
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (obs8() !== exp8() || bus8.value !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL seq_step%0d: got %h expected %h (value %h)", i, obs8(), exp8(),
                 exp_seq[i]);
      end
    end
    bus8.run = 1'b0;
    n_checks++;
    if (bus8.count !== 8'd6 || bus8.seg !== seg88) begin
      n_fail++;
      $display("FAIL seq_count_seg: got count %0d seg %h expected 6 %h", bus8.count,
               bus8.seg, seg88);
    end
  endtask

  task automatic test_period();
    bit seen [256];
    int wraps;
    int wrap_at;
    int dups;
    wraps   = 0;
    wrap_at = -1;
    dups    = 0;
    foreach (seen[k]) seen[k] = 1'b0;
    seen[1] = 1'b1;
    bus8.seed = 8'h01;
    bus8.load = 1'b1;
    bus8.run  = 1'b1;
    cycle();
    bus8.load = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      cycle();
      n_checks++;
      if (obs8() !== exp8()) begin
        n_fail++;
        $display("FAIL period_adv%0d: got %h expected %h", i, obs8(), exp8());
      end
      if (bus8.wrap === 1'b1) begin
        wraps++;
        wrap_at = i;
      end
      if (i < 255 && seen[bus8.value]) dups++;
      seen[bus8.value] = 1'b1;
    end
    bus8.run = 1'b0;
    n_checks++;
    if (wraps != 1 || wrap_at != 255 || bus8.value !== 8'h01) begin
      n_fail++;
      $display("FAIL period_wrap: got %0d pulses last at %0d value %h expected 1 at 255 01",
               wraps, wrap_at, bus8.value);
    end
    n_checks++;
    if (dups != 0) begin
      n_fail++;
      $display("FAIL period_unique: got %0d repeats expected 0", dups);
    end
  endtask

  task automatic test_seed_fix();
    bus8.seed = 8'h00;
    bus8.load = 1'b1;
    cycle();
    bus8.load = 1'b0;
    n_checks++;
    if (bus8.value !== 8'h01 || bus8.seed_fix !== 1'b1 || obs8() !== exp8()) begin
      n_fail++;
      $display("FAIL seed_zero: got %h fix %b expected 01 1", bus8.value, bus8.seed_fix);
    end
    bus8.seed = 8'h5A;
    bus8.load = 1'b1;
    cycle();
    bus8.load = 1'b0;
    n_checks++;
    if (bus8.value !== 8'h5A || bus8.seed_fix !== 1'b0 || obs8() !== exp8()) begin
      n_fail++;
      $display("FAIL seed_5a: got %h fix %b expected 5a 0", bus8.value, bus8.seed_fix);
    end
    repeat (8) begin
      bus8.seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus8.load = 1'b1;
      cycle();
      bus8.load = 1'b0;
      n_checks++;
      if (obs8() !== exp8()) begin
        n_fail++;
        $display("FAIL seed_rand: seed %h got %h expected %h", bus8.seed, obs8(), exp8());
      end
    end
  endtask

  task automatic test_step();
    logic [7:0]  v0;
    logic [7:0]  c0;
    logic [7:0]  sd;
    int          adv_at;
    bus8.run  = 1'b0;
    bus8.step = 1'b0;
    repeat (4) cycle();
    v0     = m8.value[7:0];
    c0     = m8.count[7:0];
    adv_at = 0;
    bus8.step = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      n_checks++;
      if (obs8() !== exp8()) begin
        n_fail++;
        $display("FAIL step_hold%0d: got %h expected %h", i, obs8(), exp8());
      end
      if (adv_at == 0 && bus8.value !== v0) adv_at = i;
    end
    n_checks++;
    if (adv_at != 3 || bus8.count !== 8'(c0 + 8'd1)) begin
      n_fail++;
      $display("FAIL step_once: got edge %0d count %0d expected edge 3 count %0d",
               adv_at, bus8.count, 8'(c0 + 8'd1));
    end
    bus8.step = 1'b0;
    repeat (3) cycle();
    bus8.step = 1'b1;
    cycle();
    cycle();
    sd        = 8'($urandom_range(1, 255));
    bus8.seed = sd;
    bus8.load = 1'b1;
    cycle();
    bus8.load = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if (bus8.value !== sd || bus8.count !== 8'd0 || obs8() !== exp8()) begin
      n_fail++;
      $display("FAIL step_drop: got %h count %0d expected %h count 0", bus8.value,
               bus8.count, sd);
    end
    bus8.step = 1'b0;
  endtask

  task automatic test_wide();
    int gaps;
    int last;
    logic [15:0] prev;
    gaps = 0;
    last = 0;
    prev = 16'd0;
    bus16.seed = 16'hACE1;
    bus16.load = 1'b1;
    bus16.run  = 1'b1;
    bus16.step = 1'b0;
    cycle();
    bus16.load = 1'b0;
    n_checks++;
    if (bus16.value !== 16'hACE1) begin
      n_fail++;
      $display("FAIL wide_load: got %h expected ace1", bus16.value);
    end
    for (int i = 1; i <= 40; i++) begin
      cycle();
      n_checks++;
      if (obs16() !== exp16()) begin
        n_fail++;
        $display("FAIL wide_cyc%0d: got %h expected %h", i, obs16(), exp16());
      end
      if (bus16.count !== prev) begin
        if (i - last != 4) gaps++;
        last = i;
        prev = bus16.count;
      end
    end
    bus16.run = 1'b0;
    n_checks++;
    if (gaps != 0 || bus16.count !== 16'd10) begin
      n_fail++;
      $display("FAIL wide_rate: got %0d bad gaps count %0d expected 0 10", gaps, bus16.count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus8.step = ~bus8.step;
      if ($urandom_range(0, 7) == 0) bus8.run = ~bus8.run;
      bus8.load  = ($urandom_range(0, 15) == 0);
      bus8.seed  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus16.step = ~bus16.step;
      if ($urandom_range(0, 15) == 0) bus16.run = ~bus16.run;
      bus16.load = ($urandom_range(0, 31) == 0);
      bus16.seed = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      cycle();
      n_checks++;
      if (obs8() !== exp8()) begin
        n_fail++;
        $display("FAIL rand8_%0d: got %h expected %h", i, obs8(), exp8());
      end
      n_checks++;
      if (obs16() !== exp16()) begin
        n_fail++;
        $display("FAIL rand16_%0d: got %h expected %h", i, obs16(), exp16());
      end
    end
    bus8.load  = 1'b0;
    bus8.run   = 1'b0;
    bus8.step  = 1'b0;
    bus16.load = 1'b0;
    bus16.run  = 1'b0;
    bus16.step = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_reset_mid();
    bus8.seed = 8'h77;
    bus8.load = 1'b1;
    cycle();
    bus8.load = 1'b0;
    bus8.step = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    bus8.step = 1'b0;
    n_checks++;
    if (obs8() !== exp8() || bus8.value !== 8'h01 || bus8.count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", obs8(), exp8());
    end
    repeat (4) cycle();
    n_checks++;
    if (bus8.value !== 8'h01 || obs8() !== exp8()) begin
      n_fail++;
      $display("FAIL reset_sync_clear: got %h expected 01", bus8.value);
    end
  endtask

  initial begin
    m8  = '0;
    m16 = '0;
    bus8.load  = 1'b0;
    bus8.seed  = 8'h00;
    bus8.step  = 1'b0;
    bus8.run   = 1'b0;
    bus16.load = 1'b0;
    bus16.seed = 16'h0000;
    bus16.step = 1'b0;
    bus16.run  = 1'b0;
    test_reset();
    test_run_sequence();
    test_period();
    test_seed_fix();
    test_step();
    test_wide();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
